// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch T0-T2, execute T3-T6, drives every datapath strobe.
// Optional CU_STEP_EN adds a WAIT state so one instruction runs per Step pulse.
module control_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic [31:0]        IR,
  input  logic               Stop,
  input  logic               Step,
  output logic               PCout,
  output logic               Zhighout,
  output logic               Zlowout,
  output logic               MDRout,
  output logic               HIout,
  output logic               LOout,
  output logic               Cout,
  output logic               PCin,
  output logic               MARin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin,
  output logic               HIin,
  output logic               LOin,
  output logic               IncPC,
  output logic               Read,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic [4:0]         opcode,
  output logic               Run,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count,
  output logic [3:0]         state_dbg_o
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_ILL, S_HALT, S_WAIT
  } state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire;

  logic [4:0] op;
  logic cls_r, cls_i, cls_md, cls_un, cls_nop, cls_halt;

  assign op       = IR[31:27];
  assign cls_r    = (op >= 5'b00011) && (op <= 5'b01011);
  assign cls_i    = (op >= 5'b01100) && (op <= 5'b01110);
  assign cls_md   = (op == 5'b01111) || (op == 5'b10000);
  assign cls_un   = (op == 5'b10001) || (op == 5'b10010);
  assign cls_nop  = (op == 5'b11000);
  assign cls_halt = (op == 5'b11001);

`ifdef CU_STEP_EN
  localparam state_e RETIRE_NEXT = S_WAIT;
  logic unused_bits;
  assign unused_bits = ^IR[26:0];
`else
  localparam state_e RETIRE_NEXT = S_T0;
  logic unused_bits;
  assign unused_bits = ^{IR[26:0], Step};
`endif

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_RST;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Retire marks the last execute state; Stop is only looked at there.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (cls_nop || cls_halt)              retire  = 1'b1;
        else if (cls_r || cls_i || cls_md || cls_un) state_d = S_T4;
        else                                  state_d = S_ILL;
      end
      S_T4: begin
        if (cls_un) retire  = 1'b1;
        else        state_d = S_T5;
      end
      S_T5: begin
        if (cls_md) state_d = S_T6;
        else        retire  = 1'b1;
      end
      S_T6:   retire  = 1'b1;
      S_ILL:  state_d = S_T0;
      S_HALT: state_d = S_HALT;
`ifdef CU_STEP_EN
      S_WAIT: if (Step) state_d = S_T0;
`endif
      default: state_d = S_RST;
    endcase
    if (retire) state_d = (Stop || cls_halt) ? S_HALT : RETIRE_NEXT;
    count_d = count_q + COUNT_W'(retire);
  end

  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin}       = '0;
    {IncPC, Read, Gra, Grb, Grc, Rin, Rout}                = '0;
    opcode     = 5'b00000;
    illegal_op = 1'b0;
    Run        = !(state_q == S_RST || state_q == S_HALT);
    case (state_q)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: begin
        if (cls_r || cls_i) {Grb, Rout, Yin} = '1;
        else if (cls_md)    {Gra, Rout, Yin} = '1;
        else if (cls_un) begin
          {Grb, Rout, Zin} = '1;
          opcode = op;
        end
      end
      S_T4: begin
        if (cls_r)       {Grc, Rout, Zin} = '1;
        else if (cls_i)  {Cout, Zin} = '1;
        else if (cls_md) {Grb, Rout, Zin} = '1;
        else if (cls_un) {Zlowout, Gra, Rin} = '1;
        if (cls_r || cls_i || cls_md) opcode = op;
      end
      S_T5: begin
        if (cls_md) {Zlowout, LOin} = '1;
        else        {Zlowout, Gra, Rin} = '1;
      end
      S_T6:  {Zhighout, HIin} = '1;
      S_ILL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  assign instr_count = count_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each instruction class T-state by T-state.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear, Stop, Step;
  logic [31:0] IR;
  logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic IncPC, Read, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  opcode;
  logic        Run, illegal_op;
  logic [15:0] instr_count;
  logic [3:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  control_sequencer #(.COUNT_W(16)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop), .Step(Step),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .PCin(PCin), .MARin(MARin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .opcode(opcode), .Run(Run), .illegal_op(illegal_op),
    .instr_count(instr_count), .state_dbg_o(state_dbg)
  );

  always #5 Clock = ~Clock;

  localparam logic [21:0] M_PCOUT = 22'd1 << 21, M_ZHI = 22'd1 << 20, M_ZLO = 22'd1 << 19,
    M_MDROUT = 22'd1 << 18, M_COUT = 22'd1 << 15, M_PCIN = 22'd1 << 14, M_MARIN = 22'd1 << 13,
    M_MDRIN = 22'd1 << 12, M_IRIN = 22'd1 << 11, M_YIN = 22'd1 << 10, M_ZIN = 22'd1 << 9,
    M_HIIN = 22'd1 << 8, M_LOIN = 22'd1 << 7, M_INCPC = 22'd1 << 6, M_READ = 22'd1 << 5,
    M_GRA = 22'd1 << 4, M_GRB = 22'd1 << 3, M_GRC = 22'd1 << 2, M_RIN = 22'd1 << 1,
    M_ROUT = 22'd1;

  logic [21:0] strobes;
  assign strobes = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, PCin, MARin, MDRin,
                    IRin, Yin, Zin, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [21:0] s, input logic run,
                              input logic [4:0] op, input logic ill);
    check({tag, ".strobes"}, 32'(strobes), 32'(s));
    check({tag, ".run"}, 32'(Run), 32'(run));
    check({tag, ".opcode"}, 32'(opcode), 32'(op));
    check({tag, ".illegal"}, 32'(illegal_op), 32'(ill));
    check({tag, ".count"}, 32'(instr_count), 32'(exp_count));
  endtask

  // Checks T0..T2 and leaves the sequencer in T3 with IR loaded.
  task automatic fetch(input string tag, input logic [31:0] ir, input bit stop_in_t1);
    expect_state({tag, ".T0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b1, 5'd0, 1'b0);
    tick();
    if (stop_in_t1) Stop = 1'b1;
    expect_state({tag, ".T1"}, M_ZLO | M_PCIN | M_READ | M_MDRIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state({tag, ".T2"}, M_MDROUT | M_IRIN, 1'b1, 5'd0, 1'b0);
    IR = ir;
    tick();
  endtask

  initial begin
    clear = 1'b1; Stop = 1'b0; Step = 1'b0; IR = 32'h0;
    tick();
    tick();
    expect_state("reset", 22'd0, 1'b0, 5'd0, 1'b0);
    clear = 1'b0;
    tick();

    // add R1,R2,R3
    fetch("add", 32'h1891_8000, 1'b0);
    expect_state("add.T3", M_GRB | M_ROUT | M_YIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("add.T4", M_GRC | M_ROUT | M_ZIN, 1'b1, 5'b00011, 1'b0);
    tick();
    expect_state("add.T5", M_ZLO | M_GRA | M_RIN, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 1;

    // mul: seven cycles T0..T6
    fetch("mul", 32'h7891_8000, 1'b0);
    expect_state("mul.T3", M_GRA | M_ROUT | M_YIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("mul.T4", M_GRB | M_ROUT | M_ZIN, 1'b1, 5'b01111, 1'b0);
    tick();
    expect_state("mul.T5", M_ZLO | M_LOIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("mul.T6", M_ZHI | M_HIIN, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 2;

    // addi
    fetch("addi", 32'h6091_0005, 1'b0);
    expect_state("addi.T3", M_GRB | M_ROUT | M_YIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("addi.T4", M_COUT | M_ZIN, 1'b1, 5'b01100, 1'b0);
    tick();
    expect_state("addi.T5", M_ZLO | M_GRA | M_RIN, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 3;

    // neg: opcode already in T3, retires at T4
    fetch("neg", 32'h8890_0000, 1'b0);
    expect_state("neg.T3", M_GRB | M_ROUT | M_ZIN, 1'b1, 5'b10001, 1'b0);
    tick();
    expect_state("neg.T4", M_ZLO | M_GRA | M_RIN, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 4;

    // nop retires at T3
    fetch("nop", 32'hC000_0000, 1'b0);
    expect_state("nop.T3", 22'd0, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 5;

    // illegal opcode 11111
    fetch("ill", 32'hF800_0000, 1'b0);
    expect_state("ill.T3", 22'd0, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("ill.ILL", 22'd0, 1'b1, 5'd0, 1'b1);
    tick();
    check("ill.state_after", 32'(state_dbg), 32'd1);

    // and with Stop raised in T1: completes, then HALT
    fetch("and", 32'h2891_8000, 1'b1);
    expect_state("and.T3", M_GRB | M_ROUT | M_YIN, 1'b1, 5'd0, 1'b0);
    tick();
    expect_state("and.T4", M_GRC | M_ROUT | M_ZIN, 1'b1, 5'b00101, 1'b0);
    tick();
    expect_state("and.T5", M_ZLO | M_GRA | M_RIN, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 6;
    expect_state("and.halt", 22'd0, 1'b0, 5'd0, 1'b0);
    Stop = 1'b0;
    tick();
    tick();
    expect_state("and.halt_hold", 22'd0, 1'b0, 5'd0, 1'b0);
    clear = 1'b1;
    tick();
    exp_count = 0;
    expect_state("and.clear", 22'd0, 1'b0, 5'd0, 1'b0);
    clear = 1'b0;
    tick();

    // halt instruction, counted as retired
    fetch("halt", 32'hC800_0000, 1'b0);
    expect_state("halt.T3", 22'd0, 1'b1, 5'd0, 1'b0);
    tick();
    exp_count = 1;
    expect_state("halt.HALT", 22'd0, 1'b0, 5'd0, 1'b0);
    clear = 1'b1;
    tick();
    exp_count = 0;
    clear = 1'b0;
    tick();

    // clear mid-T4 aborts the instruction
    fetch("abort", 32'h1891_8000, 1'b0);
    expect_state("abort.T3", M_GRB | M_ROUT | M_YIN, 1'b1, 5'd0, 1'b0);
    tick();
    clear = 1'b1;
    expect_state("abort.T4", M_GRC | M_ROUT | M_ZIN, 1'b1, 5'b00011, 1'b0);
    tick();
    expect_state("abort.RST", 22'd0, 1'b0, 5'd0, 1'b0);
    check("abort.state", 32'(state_dbg), 32'd0);
    clear = 1'b0;
    tick();
    expect_state("abort.T0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 1'b1, 5'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
